// File: rtl/pipe_ctl.sv
// Pipeline control: stall vector, flush/redirect sequencing, exception deferral.
// Define PIPE_CTL_PERF_EN to add the stall-cycle and flush-entry counters.
module pipe_ctl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic        ck_i,
  input  logic        rs_i,
  input  logic        stall_req_if_i,
  input  logic        stall_req_id_i,
  input  logic        stall_req_ex_i,
  input  logic        stall_req_mem_i,
  input  logic        br_redirect_i,
  input  logic [31:0] br_pc_i,
  input  logic        excp_valid_i,
  input  logic [31:0] excp_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o
`ifdef PIPE_CTL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
`endif
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_param_err
    $error("pipe_ctl: FLUSH_CYCLES must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {StIdle, StFlush, StWaitMem} state_e;

  localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        enter_flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_pc_d   = pend_pc_q;
    new_pc_d    = new_pc_q;
    enter_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (excp_valid_i) begin
          if (stall_req_mem_i) begin
            pend_pc_d = excp_pc_i;
            state_d   = StWaitMem;
          end else begin
            enter_flush = 1'b1;
            new_pc_d    = excp_pc_i;
          end
        end else if (br_redirect_i && !stall_req_mem_i) begin
          enter_flush = 1'b1;
          new_pc_d    = br_pc_i;
        end
      end
      StFlush: begin
        // Branches here are wrong-path; only an exception restarts the flush.
        if (excp_valid_i) begin
          enter_flush = 1'b1;
          new_pc_d    = excp_pc_i;
        end else if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWaitMem: begin
        if (!stall_req_mem_i) begin
          enter_flush = 1'b1;
          new_pc_d    = excp_valid_i ? excp_pc_i : pend_pc_q;
        end else if (excp_valid_i) begin
          pend_pc_d = excp_pc_i;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_flush) begin
      state_d = StFlush;
      cnt_d   = FlushLast;
    end
  end

  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pend_pc_q <= 32'd0;
      new_pc_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_pc_q <= pend_pc_d;
      new_pc_q  <= new_pc_d;
    end
  end

  // Stalling stage k and everything upstream leaves k+1 free to take a bubble.
  always_comb begin
    stall_o = 6'b000000;
    if (!rs_i && state_q != StFlush) begin
      if (stall_req_mem_i)     stall_o = 6'b011111;
      else if (stall_req_ex_i) stall_o = 6'b001111;
      else if (stall_req_id_i) stall_o = 6'b000111;
      else if (stall_req_if_i) stall_o = 6'b000011;
    end
  end

  assign flush_o        = (state_q == StFlush);
  assign new_pc_valid_o = (state_q == StFlush);
  assign new_pc_o       = new_pc_q;

`ifdef PIPE_CTL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_o != 6'b000000) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (enter_flush)          flush_count_q  <= flush_count_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Bench for pipe_ctl: two instances (FLUSH_CYCLES 2 and 3) against a behavioural model.
module tb_pipe_ctl;

  logic        ck = 1'b0;
  logic        rs, sif, sid, sex, smem, br, ex;
  logic [31:0] brpc, expc;

  logic [5:0]  stall_a [2];
  logic        flush_a [2];
  logic        valid_a [2];
  logic [31:0] npc_a   [2];
`ifdef PIPE_CTL_PERF_EN
  logic [31:0] scyc_a  [2];
  logic [31:0] fcnt_a  [2];
`endif

  int errs   = 0;
  int checks = 0;

  always #5 ck = ~ck;

  pipe_ctl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut2 (
    .ck_i(ck), .rs_i(rs), .stall_req_if_i(sif), .stall_req_id_i(sid),
    .stall_req_ex_i(sex), .stall_req_mem_i(smem), .br_redirect_i(br), .br_pc_i(brpc),
    .excp_valid_i(ex), .excp_pc_i(expc), .stall_o(stall_a[0]), .flush_o(flush_a[0]),
    .new_pc_valid_o(valid_a[0]), .new_pc_o(npc_a[0])
`ifdef PIPE_CTL_PERF_EN
    , .stall_cycles_o(scyc_a[0]), .flush_count_o(fcnt_a[0])
`endif
  );

  pipe_ctl #(.FLUSH_CYCLES(3), .CNT_W(32)) u_dut3 (
    .ck_i(ck), .rs_i(rs), .stall_req_if_i(sif), .stall_req_id_i(sid),
    .stall_req_ex_i(sex), .stall_req_mem_i(smem), .br_redirect_i(br), .br_pc_i(brpc),
    .excp_valid_i(ex), .excp_pc_i(expc), .stall_o(stall_a[1]), .flush_o(flush_a[1]),
    .new_pc_valid_o(valid_a[1]), .new_pc_o(npc_a[1])
`ifdef PIPE_CTL_PERF_EN
    , .stall_cycles_o(scyc_a[1]), .flush_count_o(fcnt_a[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Model: rem = flush cycles still owed, defer = exception waiting on a memory stall.
  int          rem   [2];
  bit          defer [2];
  logic [31:0] pend  [2];
  logic [31:0] opc   [2];
  logic [31:0] mscyc [2];
  logic [31:0] mfcnt [2];
  bit          mvalid = 1'b0;

  function automatic int flen(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic logic [5:0] exp_stall(input int i);
    if (rs || rem[i] > 0) return 6'b000000;
    if (smem) return 6'b011111;
    if (sex)  return 6'b001111;
    if (sid)  return 6'b000111;
    if (sif)  return 6'b000011;
    return 6'b000000;
  endfunction

  always @(posedge ck) begin
    if (rs) begin
      mvalid <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        rem[i] <= 0; defer[i] <= 1'b0; pend[i] <= '0; opc[i] <= '0;
        mscyc[i] <= '0; mfcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (exp_stall(i) != 6'b0) mscyc[i] <= mscyc[i] + 1;
        if (rem[i] > 0) begin
          if (ex) begin
            rem[i] <= flen(i); opc[i] <= expc; mfcnt[i] <= mfcnt[i] + 1;
          end else rem[i] <= rem[i] - 1;
        end else if (defer[i]) begin
          if (!smem) begin
            rem[i] <= flen(i); defer[i] <= 1'b0; opc[i] <= ex ? expc : pend[i];
            mfcnt[i] <= mfcnt[i] + 1;
          end else if (ex) pend[i] <= expc;
        end else if (ex) begin
          if (smem) begin
            defer[i] <= 1'b1; pend[i] <= expc;
          end else begin
            rem[i] <= flen(i); opc[i] <= expc; mfcnt[i] <= mfcnt[i] + 1;
          end
        end else if (br && !smem) begin
          rem[i] <= flen(i); opc[i] <= brpc; mfcnt[i] <= mfcnt[i] + 1;
        end
      end
    end
  end

  always @(negedge ck) begin
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_stall%0d", i), 32'(stall_a[i]), 32'(exp_stall(i)));
        chk($sformatf("model_flush%0d", i), 32'(flush_a[i]), 32'(rem[i] > 0));
        chk($sformatf("model_valid%0d", i), 32'(valid_a[i]), 32'(rem[i] > 0));
        chk($sformatf("model_newpc%0d", i), npc_a[i], opc[i]);
`ifdef PIPE_CTL_PERF_EN
        chk($sformatf("model_scyc%0d", i), scyc_a[i], mscyc[i]);
        chk($sformatf("model_fcnt%0d", i), fcnt_a[i], mfcnt[i]);
`endif
      end
    end
  end

  task automatic nxt();
    @(posedge ck);
    #1;
  endtask

  task automatic clr();
    rs = 0; sif = 0; sid = 0; sex = 0; smem = 0; br = 0; ex = 0; brpc = '0; expc = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rs = 1; sif = 1; sid = 1; sex = 1; smem = 1; br = 1; brpc = 32'h55; ex = 1; expc = 32'h66;
    repeat (2) @(posedge ck);
    #1;
    @(negedge ck);
    chk("reset_stall", 32'(stall_a[0]), 32'h0);
    chk("reset_flush", 32'(flush_a[0]), 32'h0);
    chk("reset_newpc", npc_a[0], 32'h0);

    nxt(); clr(); sex = 1;
    @(negedge ck); chk("ex_stall", 32'(stall_a[0]), 32'h0f);
    nxt(); clr(); sid = 1; smem = 1;
    @(negedge ck); chk("id_mem_stall", 32'(stall_a[0]), 32'h1f);
    nxt(); smem = 0;
    @(negedge ck); chk("id_stall", 32'(stall_a[0]), 32'h07);

    // Branch redirect, stall forced off while flushing.
    nxt(); clr(); br = 1; brpc = 32'h100;
    @(negedge ck); chk("br_noflush_yet", 32'(flush_a[0]), 32'h0);
    nxt(); clr(); sex = 1;
    @(negedge ck);
    chk("br_flush1", 32'(flush_a[0]), 32'h1);
    chk("br_valid1", 32'(valid_a[0]), 32'h1);
    chk("br_newpc", npc_a[0], 32'h100);
    chk("flush_stall0", 32'(stall_a[0]), 32'h0);
    nxt();
    @(negedge ck); chk("br_flush2", 32'(flush_a[0]), 32'h1);
    nxt();
    @(negedge ck);
    chk("br_flush_end", 32'(flush_a[0]), 32'h0);
    chk("br_stall_back", 32'(stall_a[0]), 32'h0f);
    chk("br_flush3_len3", 32'(flush_a[1]), 32'h1);
    nxt(); clr(); nxt();

    // Exception beats a simultaneous branch.
    ex = 1; expc = 32'h800; br = 1; brpc = 32'h200;
    nxt(); clr();
    @(negedge ck); chk("excp_prio_pc", npc_a[0], 32'h800);
    repeat (4) nxt();

    // Exception deferred behind a memory stall; branches ignored meanwhile.
    ex = 1; expc = 32'h40; smem = 1;
    nxt(); clr(); smem = 1; br = 1; brpc = 32'h999;
    for (int k = 0; k < 5; k++) begin
      @(negedge ck);
      chk("wait_noflush", 32'(flush_a[0]), 32'h0);
      chk("wait_stall", 32'(stall_a[0]), 32'h1f);
      nxt();
    end
    clr();
    @(negedge ck); chk("wait_release_noflush", 32'(flush_a[0]), 32'h0);
    nxt();
    @(negedge ck);
    chk("wait_flush", 32'(flush_a[0]), 32'h1);
    chk("wait_newpc", npc_a[0], 32'h40);
    repeat (4) nxt();

    // Newer exception overwrites the deferred target.
    ex = 1; expc = 32'h10; smem = 1;
    nxt(); expc = 32'h20;
    nxt(); clr();
    nxt();
    @(negedge ck); chk("wait_overwrite_pc", npc_a[0], 32'h20);
    repeat (4) nxt();

    // Exception during flush restarts it with the new target.
    br = 1; brpc = 32'h300;
    nxt(); clr(); ex = 1; expc = 32'h400;
    @(negedge ck); chk("restart_pc_before", npc_a[0], 32'h300);
    nxt(); clr();
    @(negedge ck); chk("restart_pc_after", npc_a[0], 32'h400);
    nxt();
    @(negedge ck); chk("restart_flush_held", 32'(flush_a[0]), 32'h1);
    repeat (5) nxt();

    // Branch during a memory stall is dropped.
    br = 1; brpc = 32'h700; smem = 1;
    nxt(); clr();
    @(negedge ck); chk("br_mem_ignored", 32'(flush_a[0]), 32'h0);
    nxt();

    // Reset on the first flush cycle clears it.
    br = 1; brpc = 32'h500;
    nxt(); clr(); rs = 1;
    @(negedge ck); chk("rst_flush_first", 32'(flush_a[1]), 32'h1);
    nxt(); clr();
    @(negedge ck);
    chk("rst_flush_gone3", 32'(flush_a[1]), 32'h0);
    chk("rst_flush_gone2", 32'(flush_a[0]), 32'h0);
    chk("rst_newpc", npc_a[1], 32'h0);

    nxt(); sex = 1;
    repeat (7) nxt();
    clr();
`ifdef PIPE_CTL_PERF_EN
    @(negedge ck);
    chk("perf_stall7", scyc_a[0], 32'd7);
    chk("perf_fcnt0", fcnt_a[0], 32'd0);
`endif
    nxt(); br = 1; brpc = 32'h600;
    nxt(); clr();
`ifdef PIPE_CTL_PERF_EN
    @(negedge ck);
    chk("perf_fcnt1", fcnt_a[0], 32'd1);
`endif
    repeat (5) nxt();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
